vga_timing_ctrl: RTL
====================

// Module: vga_timing_ctrl
// PURPOSE
//  Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
//  Drives hsync/vsync to the connector, and display_en to the colour mux select; display_en blanks RGB outside the visible area.
//  Supplies pixel_x/pixel_y and line/frame strobes to the pixel-source logic.
//  Each axis is sequenced by a 4-phase state machine with a position counter.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (clocks)
//  H_SYNC    96   hsync pulse width (clocks)
//  H_BP      48   horizontal back porch (clocks)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
//  CW        10   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1   25 MHz pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = advance raster; 0 = freeze all state
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  h_display    out  1   1 while horizontal phase is ACTIVE
//  v_display    out  1   1 while vertical phase is ACTIVE
//  display_en   out  1   h_display & v_display (colour mux select)
//  pixel_x      out  CW  horizontal position, 0..H_TOTAL-1
//  pixel_y      out  CW  vertical position, 0..V_TOTAL-1
//  line_start   out  1   1-clk pulse when pixel_x becomes 0
//  frame_start  out  1   1-clk pulse when (pixel_x,pixel_y) becomes (0,0)
// BEHAVIOUR
//  - Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
//  - Derived totals: V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Per-axis FSM phases are ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
//    H axis: ACTIVE x 0..639; FRONT x 640..655; SYNC x 656..751; BACK x 752..799.
//    V axis: same phase order, with boundaries at y = 480, 490, 492, 525.
//  - H counter advances on every enabled clk and wraps at H_TOTAL-1 -> 0.
//  - V counter advances only on the H wrap clk, and wraps at V_TOTAL-1 -> 0.
//  - All outputs are registered and mutually aligned. In the cycle pixel_x == N:
//    h_display, hsync and line_start describe position N.
//    The same holds for the V-axis outputs and pixel_y.
//  - hsync = SYNC_POL while the H phase is SYNC, else ~SYNC_POL; vsync likewise.
//  - vsync changes only on the same clk in which the H counter wraps to 0.
//  - display_en = h_display & v_display; it is never 1 outside the 640x480 area.
//  - Reset (async assert, sync release), all set to the end-of-frame position:
//    pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1, both phases BACK.
//    hsync = vsync = ~SYNC_POL.
//    h_display = v_display = display_en = 0; line_start = frame_start = 0.
//  - First enabled clk after reset: position becomes (0,0).
//    On that clk frame_start = line_start = 1 and display_en = 1.
//  - enable = 0: counters, phases and levels hold; line_start/frame_start forced 0.
//    When enable returns to 1, the raster resumes from the held position.
//  - Reset asserted mid-frame: immediate return to the reset state; no partial sync pulse is extended.
//  - Phase transitions are decoded from the next counter value, so the outputs have no 1-clk skew against the counters.
// TESTING
//  - Reset release, enable = 1: 1st clk gives (0,0), frame_start = 1, display_en = 1.
//    Frame period is exactly 420000 clks.
//  - Line timing: display_en high for 640 clks, low for 160 clks.
//    hsync low for x 656..751 (96 clks); line_start every 800 clks.
//  - Frame timing: vsync low for y 490..491, i.e. 1600 clks.
//    vsync edges coincide with pixel_x = 0; display_en = 0 for all y >= 480.
//  - Hold enable = 0 for 37 clks at x = 639, y = 10: all outputs constant.
//    Next enabled clk gives x = 640, display_en = 0, with no extra strobe.
//  - Assert rst_n = 0 at x = 700, y = 491 (inside both sync pulses):
//    hsync and vsync go high asynchronously; state is (799,524).
//  - SYNC_POL = 1 build: sync pulses invert, all timing is identical.
//    Assertion over 2 frames: display_en == (x < 640 && y < 480).

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: two cascaded axis sequencers (pixel, line), each a
// 4-phase FSM with a position counter; every output is registered and mutually aligned.

module vga_axis #(
   parameter int   ACT      = 640,
   parameter int   FP       = 16,
   parameter int   SYNC     = 96,
   parameter int   BP       = 48,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adv,
   output logic [CW-1:0] pos,
   output logic          disp,
   output logic          disp_nxt,
   output logic          sync,
   output logic          wrap
);
   localparam int TOTAL = ACT + FP + SYNC + BP;
   localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
   localparam logic [CW-1:0] B_FRONT = CW'(ACT);
   localparam logic [CW-1:0] B_SYNC  = CW'(ACT + FP);
   localparam logic [CW-1:0] B_BACK  = CW'(ACT + FP + SYNC);

   typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

   phase_e        phase_q, phase_d;
   logic [CW-1:0] pos_q, pos_d;
   logic          disp_q, disp_d;
   logic          sync_q, sync_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_BACK;
         pos_q   <= LAST;
         disp_q  <= 1'b0;
         sync_q  <= ~SYNC_POL;
      end else begin
         phase_q <= phase_d;
         pos_q   <= pos_d;
         disp_q  <= disp_d;
         sync_q  <= sync_d;
      end
   end

   // Phase is decoded from the next position so the registered levels line up with pos_q.
   always_comb begin
      wrap    = adv && (pos_q == LAST);
      pos_d   = pos_q;
      phase_d = phase_q;
      if (adv) pos_d = wrap ? '0 : pos_q + CW'(1);
      case (phase_q)
         PH_ACTIVE: if (pos_d == B_FRONT) phase_d = PH_FRONT;
         PH_FRONT:  if (pos_d == B_SYNC)  phase_d = PH_SYNC;
         PH_SYNC:   if (pos_d == B_BACK)  phase_d = PH_BACK;
         PH_BACK:   if (pos_d == '0)      phase_d = PH_ACTIVE;
         default:   phase_d = PH_BACK;
      endcase
      disp_d = (phase_d == PH_ACTIVE);
      sync_d = (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
   end

   assign pos      = pos_q;
   assign disp     = disp_q;
   assign disp_nxt = disp_d;
   assign sync     = sync_q;
endmodule

module vga_timing_ctrl #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   output logic          hsync,
   output logic          vsync,
   output logic          h_display,
   output logic          v_display,
   output logic          display_en,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          line_start,
   output logic          frame_start
);
   logic h_wrap, v_wrap, h_disp_nxt, v_disp_nxt;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic display_en_q, display_en_d;

   vga_axis #(.ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
              .SYNC_POL(SYNC_POL), .CW(CW)) u_h (
      .clk(clk), .rst_n(rst_n), .adv(enable), .pos(pixel_x), .disp(h_display),
      .disp_nxt(h_disp_nxt), .sync(hsync), .wrap(h_wrap)
   );

   // The line axis steps only on the pixel-axis wrap, so vsync edges land on pixel_x == 0.
   vga_axis #(.ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
              .SYNC_POL(SYNC_POL), .CW(CW)) u_v (
      .clk(clk), .rst_n(rst_n), .adv(h_wrap), .pos(pixel_y), .disp(v_display),
      .disp_nxt(v_disp_nxt), .sync(vsync), .wrap(v_wrap)
   );

   always_comb begin
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
      display_en_d  = h_disp_nxt && v_disp_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         display_en_q  <= 1'b0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         display_en_q  <= display_en_d;
      end
   end

   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign display_en  = display_en_q;
endmodule
